// File: rtl/wfq_div_stage.sv
// WFQ divide stage: per-class weight table plus restoring divider (pkt_len / weight).
// Define WFQ_DIV_POW2_FAST_EN to resolve power-of-two weights in a single cycle.
module wfq_div_stage #(
    parameter int unsigned CLASS_WIDTH  = 5,
    parameter int unsigned PKT_WIDTH    = 16,
    parameter int unsigned WEIGHT_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [CLASS_WIDTH-1:0]  in_class_id_i,
    input  logic [PKT_WIDTH-1:0]    in_pkt_len_i,
    input  logic                    cfg_wr_en_i,
    input  logic [CLASS_WIDTH-1:0]  cfg_class_id_i,
    input  logic [WEIGHT_WIDTH-1:0] cfg_weight_i,
    output logic                    out_valid_o,
    output logic [CLASS_WIDTH-1:0]  out_class_id_o,
    output logic [WEIGHT_WIDTH-1:0] out_div_quotient_o,
    output logic [WEIGHT_WIDTH-1:0] out_div_remain_o,
    output logic [15:0]             div_zero_cnt_o
);
    localparam int unsigned ClassIdCount = 2 ** CLASS_WIDTH;
    localparam int unsigned CntWidth     = $clog2(PKT_WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

    state_e                  state_q, state_d;
    logic [WEIGHT_WIDTH-1:0] weight_q [ClassIdCount];
    logic [CLASS_WIDTH-1:0]  cls_q, cls_d;
    logic [WEIGHT_WIDTH-1:0] wgt_q, wgt_d;
    logic [PKT_WIDTH-1:0]    dvd_q, dvd_d;
    logic [WEIGHT_WIDTH-1:0] prem_q, prem_d;
    logic [CntWidth-1:0]     cnt_q, cnt_d;
    logic [CLASS_WIDTH-1:0]  out_class_q, out_class_d;
    logic [WEIGHT_WIDTH-1:0] out_quo_q, out_quo_d;
    logic [WEIGHT_WIDTH-1:0] out_rem_q, out_rem_d;
    logic [15:0]             zero_cnt_q, zero_cnt_d;

    logic [WEIGHT_WIDTH-1:0] w_sel;
    logic [WEIGHT_WIDTH:0]   trial, diff;
    logic                    ge;
    logic [WEIGHT_WIDTH-1:0] prem_step;
    logic [PKT_WIDTH-1:0]    dvd_step;
    logic                    unused_diff_msb;

    assign w_sel = weight_q[in_class_id_i];

    // One restoring step: the shifted-in dividend bit needs WEIGHT_WIDTH+1 bits of headroom.
    assign trial           = {prem_q, dvd_q[PKT_WIDTH-1]};
    assign diff            = trial - {1'b0, wgt_q};
    assign ge              = trial >= {1'b0, wgt_q};
    assign prem_step       = ge ? diff[WEIGHT_WIDTH-1:0] : trial[WEIGHT_WIDTH-1:0];
    assign dvd_step        = {dvd_q[PKT_WIDTH-2:0], ge};
    assign unused_diff_msb = diff[WEIGHT_WIDTH];

`ifdef WFQ_DIV_POW2_FAST_EN
    logic                    is_pow2;
    logic [WEIGHT_WIDTH-1:0] pkt_ext, pow2_quo, pow2_rem;

    assign pkt_ext  = WEIGHT_WIDTH'(in_pkt_len_i);
    assign is_pow2  = ((w_sel & (w_sel - WEIGHT_WIDTH'(1))) == '0);
    assign pow2_rem = pkt_ext & (w_sel - WEIGHT_WIDTH'(1));

    always_comb begin
        pow2_quo = '0;
        for (int i = 0; i < int'(WEIGHT_WIDTH); i++) begin
            if (w_sel == (WEIGHT_WIDTH'(1) << i)) pow2_quo = pkt_ext >> i;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        wgt_d       = wgt_q;
        dvd_d       = dvd_q;
        prem_d      = prem_q;
        cnt_d       = cnt_q;
        out_class_d = out_class_q;
        out_quo_d   = out_quo_q;
        out_rem_d   = out_rem_q;
        zero_cnt_d  = zero_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    cls_d  = in_class_id_i;
                    wgt_d  = w_sel;
                    dvd_d  = in_pkt_len_i;
                    prem_d = '0;
                    cnt_d  = '0;
                    if (w_sel == '0) begin
                        out_class_d = in_class_id_i;
                        out_quo_d   = '1;
                        out_rem_d   = '0;
                        if (zero_cnt_q != 16'hFFFF) zero_cnt_d = zero_cnt_q + 16'd1;
                        state_d = StDone;
`ifdef WFQ_DIV_POW2_FAST_EN
                    end else if (is_pow2) begin
                        out_class_d = in_class_id_i;
                        out_quo_d   = pow2_quo;
                        out_rem_d   = pow2_rem;
                        state_d     = StDone;
`endif
                    end else begin
                        state_d = StDiv;
                    end
                end
            end
            StDiv: begin
                prem_d = prem_step;
                dvd_d  = dvd_step;
                cnt_d  = cnt_q + CntWidth'(1);
                if (cnt_q == CntWidth'(PKT_WIDTH - 1)) begin
                    out_class_d = cls_q;
                    out_quo_d   = WEIGHT_WIDTH'(dvd_step);
                    out_rem_d   = prem_step;
                    state_d     = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cls_q       <= '0;
            wgt_q       <= '0;
            dvd_q       <= '0;
            prem_q      <= '0;
            cnt_q       <= '0;
            out_class_q <= '0;
            out_quo_q   <= '0;
            out_rem_q   <= '0;
            zero_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cls_q       <= cls_d;
            wgt_q       <= wgt_d;
            dvd_q       <= dvd_d;
            prem_q      <= prem_d;
            cnt_q       <= cnt_d;
            out_class_q <= out_class_d;
            out_quo_q   <= out_quo_d;
            out_rem_q   <= out_rem_d;
            zero_cnt_q  <= zero_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(ClassIdCount); i++) weight_q[i] <= WEIGHT_WIDTH'(1);
        end else if (cfg_wr_en_i) begin
            weight_q[cfg_class_id_i] <= cfg_weight_i;
        end
    end

    assign in_ready_o         = (state_q == StIdle);
    assign out_valid_o        = (state_q == StDone);
    assign out_class_id_o     = out_class_q;
    assign out_div_quotient_o = out_quo_q;
    assign out_div_remain_o   = out_rem_q;
    assign div_zero_cnt_o     = zero_cnt_q;

endmodule

// File: tb/tb_wfq_div_stage.sv
// Directed self-checking bench for wfq_div_stage (default parameters).
module tb_wfq_div_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_class_id;
    logic [15:0] in_pkt_len;
    logic        cfg_wr_en;
    logic [4:0]  cfg_class_id;
    logic [15:0] cfg_weight;
    logic        out_valid;
    logic [4:0]  out_class_id;
    logic [15:0] out_div_quotient;
    logic [15:0] out_div_remain;
    logic [15:0] div_zero_cnt;

    int checks = 0;
    int errors = 0;

`ifdef WFQ_DIV_POW2_FAST_EN
    localparam int LatP2 = 1;
`else
    localparam int LatP2 = 17;
`endif
    localparam int LatDiv = 17;

    wfq_div_stage dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .in_valid_i         (in_valid),
        .in_ready_o         (in_ready),
        .in_class_id_i      (in_class_id),
        .in_pkt_len_i       (in_pkt_len),
        .cfg_wr_en_i        (cfg_wr_en),
        .cfg_class_id_i     (cfg_class_id),
        .cfg_weight_i       (cfg_weight),
        .out_valid_o        (out_valid),
        .out_class_id_o     (out_class_id),
        .out_div_quotient_o (out_div_quotient),
        .out_div_remain_o   (out_div_remain),
        .div_zero_cnt_o     (div_zero_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [4:0] cls, input logic [15:0] w);
        @(negedge clk);
        cfg_wr_en = 1'b1; cfg_class_id = cls; cfg_weight = w;
        @(negedge clk);
        cfg_wr_en = 1'b0;
    endtask

    // Accept one request (optionally with a same-cycle cfg write) and check result and latency.
    task automatic run(input string tag, input logic [4:0] cls, input logic [15:0] pkt,
                       input logic [15:0] exp_q, input logic [15:0] exp_r, input int exp_lat,
                       input logic cfg_en, input logic [4:0] ccls, input logic [15:0] cw);
        int n;
        @(negedge clk);
        check({tag, ".ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_class_id = cls; in_pkt_len = pkt;
        cfg_wr_en = cfg_en; cfg_class_id = ccls; cfg_weight = cw;
        @(negedge clk);
        in_valid = 1'b0; cfg_wr_en = 1'b0; in_class_id = 5'd31; in_pkt_len = 16'hDEAD;
        n = 1;
        if (exp_lat > 1) check({tag, ".busy"}, {31'd0, in_ready}, 32'd0);
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".lat"}, n, exp_lat);
        check({tag, ".cls"}, {27'd0, out_class_id}, {27'd0, cls});
        check({tag, ".quo"}, {16'd0, out_div_quotient}, {16'd0, exp_q});
        check({tag, ".rem"}, {16'd0, out_div_remain}, {16'd0, exp_r});
        @(negedge clk);
        check({tag, ".pulse"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".hold"}, {16'd0, out_div_quotient}, {16'd0, exp_q});
        check({tag, ".reready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; in_class_id = '0; in_pkt_len = '0;
        cfg_wr_en = 1'b0; cfg_class_id = '0; cfg_weight = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst.ready", {31'd0, in_ready}, 32'd1);
        check("rst.valid", {31'd0, out_valid}, 32'd0);
        check("rst.cls", {27'd0, out_class_id}, 32'd0);
        check("rst.quo", {16'd0, out_div_quotient}, 32'd0);
        check("rst.rem", {16'd0, out_div_remain}, 32'd0);
        check("rst.zcnt", {16'd0, div_zero_cnt}, 32'd0);

        run("w1", 5'd0, 16'd9, 16'd9, 16'd0, LatP2, 1'b0, 5'd0, 16'd0);

        cfg_write(5'd3, 16'd3);
        cfg_write(5'd7, 16'd7);
        cfg_write(5'd2, 16'd0);
        cfg_write(5'd5, 16'd8);
        cfg_write(5'd9, 16'd65534);
        cfg_write(5'd10, 16'd7);

        run("w3", 5'd3, 16'd1500, 16'd500, 16'd0, LatDiv, 1'b0, 5'd0, 16'd0);
        run("w7", 5'd7, 16'd1000, 16'd142, 16'd6, LatDiv, 1'b0, 5'd0, 16'd0);
        run("w0a", 5'd2, 16'd64, 16'hFFFF, 16'd0, 1, 1'b0, 5'd0, 16'd0);
        check("zcnt1", {16'd0, div_zero_cnt}, 32'd1);
        run("w8", 5'd5, 16'd1501, 16'd187, 16'd5, LatP2, 1'b0, 5'd0, 16'd0);
        run("wmax", 5'd9, 16'd65535, 16'd1, 16'd1, LatDiv, 1'b0, 5'd0, 16'd0);
        run("small", 5'd10, 16'd5, 16'd0, 16'd5, LatDiv, 1'b0, 5'd0, 16'd0);
        run("cfgacc", 5'd4, 16'd100, 16'd100, 16'd0, LatP2, 1'b1, 5'd4, 16'd10);
        run("cfgnew", 5'd4, 16'd100, 16'd10, 16'd0, LatDiv, 1'b0, 5'd0, 16'd0);
        run("w0b", 5'd2, 16'd0, 16'hFFFF, 16'd0, 1, 1'b0, 5'd0, 16'd0);
        check("zcnt2", {16'd0, div_zero_cnt}, 32'd2);

        // Abort an in-flight division with reset; a cfg write during reset must be dropped.
        @(negedge clk);
        check("abort.ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_class_id = 5'd3; in_pkt_len = 16'd1500;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1; cfg_wr_en = 1'b1; cfg_class_id = 5'd6; cfg_weight = 16'd5;
        @(negedge clk);
        rst = 1'b0; cfg_wr_en = 1'b0;
        check("abort.reready", {31'd0, in_ready}, 32'd1);
        check("abort.zcnt", {16'd0, div_zero_cnt}, 32'd0);
        check("abort.quo", {16'd0, out_div_quotient}, 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        check("abort.novalid", seen, 0);
        run("postrst", 5'd3, 16'd9, 16'd9, 16'd0, LatP2, 1'b0, 5'd0, 16'd0);
        run("rstcfg", 5'd6, 16'd9, 16'd9, 16'd0, LatP2, 1'b0, 5'd0, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wfq_div_stage.md
WFQ_DIV_STAGE -- requirements
Module: wfq_div_stage

Interface
REQ-001 The block SHALL have parameter CLASS_WIDTH, default 5: class-ID width; CLASS_ID_COUNT = 2**CLASS_WIDTH.
REQ-002 The block SHALL have parameter PKT_WIDTH, default 16: packet-length (dividend) width.
REQ-003 The block SHALL have parameter WEIGHT_WIDTH, default 16: weight (divisor), quotient and remainder width; PKT_WIDTH <= WEIGHT_WIDTH.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block can accept a request this cycle.
REQ-008 in_class_id  input  CLASS_WIDTH  class of packet.
REQ-009 in_pkt_len  input  PKT_WIDTH  packet length in bytes.
REQ-010 cfg_wr_en  input  1  weight-table write strobe.
REQ-011 cfg_class_id  input  CLASS_WIDTH  weight-table write index.
REQ-012 cfg_weight  input  WEIGHT_WIDTH  weight value to write.
REQ-013 out_valid  output  1  single-cycle result pulse; there is no backpressure (the downstream WFQ engine always accepts).
REQ-014 out_class_id  output  CLASS_WIDTH  class of the result.
REQ-015 out_div_quotient  output  WEIGHT_WIDTH  floor(pkt_len / weight), zero-extended.
REQ-016 out_div_remain  output  WEIGHT_WIDTH  pkt_len mod weight, zero-extended.
REQ-017 div_zero_cnt  output  16  count of requests seen with weight 0; saturates at 0xFFFF.

Function
REQ-018 The weight table SHALL hold CLASS_ID_COUNT registered entries, written when cfg_wr_en=1; the write takes effect on the next cycle.
REQ-019 The FSM SHALL have states IDLE, DIV and DONE; in_ready=1 only in IDLE.
REQ-020 A request SHALL be accepted on in_valid & in_ready; the block latches class, pkt_len and the table weight current in that cycle, then moves to DIV.
REQ-021 A cfg write to the same class in the accept cycle SHALL NOT affect the accepted request; the old weight is used.
REQ-022 DIV SHALL run restoring division, one quotient bit per cycle, MSB first, for exactly PKT_WIDTH cycles, then move to DONE.
REQ-023 Subtraction in DIV SHALL use a WEIGHT_WIDTH+1-bit partial remainder so that no intermediate overflow occurs.
REQ-024 In DONE, out_valid=1 for exactly one cycle with the registered quotient, remainder and class; the next state is IDLE.
REQ-025 Latency SHALL be fixed: out_valid in cycle accept+PKT_WIDTH+1; in_ready reasserts at accept+PKT_WIDTH+2.
REQ-026 With weight 0, the block SHALL skip DIV (IDLE->DONE) and output quotient all-ones, remainder 0, and increment div_zero_cnt.
REQ-027 Outside DONE, out_valid=0 and the out_* data outputs SHALL hold their last values.

Reset
REQ-028 On rst=1 at a clock edge, the FSM SHALL go to IDLE and any in-flight division SHALL be discarded without an out_valid.
REQ-029 Reset values: in_ready=1 (the cycle after reset), out_valid=0, out_class_id=0, out_div_quotient=0, out_div_remain=0, div_zero_cnt=0, all weights=1.
REQ-030 A cfg write during rst SHALL be ignored.

Configuration
REQ-031 Macro WFQ_DIV_POW2_FAST_EN SHALL enable a power-of-two shortcut.
REQ-032 With the macro defined: for a nonzero power-of-two weight 2^k, the block goes IDLE->DONE directly with quotient = pkt_len>>k and remainder = pkt_len & (2^k-1); latency is accept+1.
REQ-033 With the macro undefined: all nonzero weights use the DIV path with REQ-025 latency.
REQ-034 Numeric results SHALL be identical with and without the macro; only latency differs.

Verification
REQ-035 Weight[3]=3, pkt 1500 class 3 -> quotient 500, remainder 0, out_valid at accept+17 (PKT_WIDTH=16).
REQ-036 Weight[7]=7, pkt 1000 class 7 -> quotient 142, remainder 6, out_class_id 7.
REQ-037 Weight[2]=0, pkt 64 class 2 -> quotient 0xFFFF, remainder 0, div_zero_cnt 1, out_valid at accept+1.
REQ-038 Weight[5]=8, pkt 1501 -> quotient 187, remainder 5; latency accept+1 with WFQ_DIV_POW2_FAST_EN, accept+17 without.
REQ-039 cfg write weight[4]=10 in the accept cycle of a class-4 pkt 100 (old weight 1) -> quotient 100, remainder 0; next class-4 pkt 100 -> quotient 10.
REQ-040 rst asserted 5 cycles after accept -> no out_valid, in_ready=1 the cycle after rst deasserts, all weights read back 1 (pkt 9 -> quotient 9).
